waypoint_sequencer: RTL and testbench

//  Route controller for the car navigation FSM. Stores up to NUM_WP (X,Y)

---
 rtl/waypoint_sequencer_if.sv | 41 ++++
 rtl/waypoint_sequencer.sv | 173 +++++++++++++++++
 tb/tb_waypoint_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waypoint_sequencer_if.sv
// Bus bundle for waypoint_sequencer: waypoint load, route control, car/nav inputs
// and gated outputs. slave = the sequencer, master = whatever drives it.
interface waypoint_sequencer_if #(
  parameter int NUM_WP  = 8,
  parameter int COORD_W = 32
);
  localparam int AW = $clog2(NUM_WP);

  logic               wp_we;
  logic [AW-1:0]      wp_addr;
  logic [COORD_W-1:0] wp_x;
  logic [COORD_W-1:0] wp_y;
  logic               start;
  logic [AW:0]        route_len;
  logic               abort;
  logic [COORD_W-1:0] carX;
  logic [COORD_W-1:0] carY;
  logic [1:0]         nav_rWheel;
  logic [1:0]         nav_lWheel;
  logic [COORD_W-1:0] tarX;
  logic [COORD_W-1:0] tarY;
  logic [1:0]         rWheel;
  logic [1:0]         lWheel;
  logic [AW-1:0]      wp_idx;
  logic               wp_arrived;
  logic               busy;
  logic               done;
  logic [2:0]         dbg_state;

  modport slave (
    input  wp_we, wp_addr, wp_x, wp_y, start, route_len, abort,
    input  carX, carY, nav_rWheel, nav_lWheel,
    output tarX, tarY, rWheel, lWheel, wp_idx, wp_arrived, busy, done, dbg_state
  );

  modport master (
    output wp_we, wp_addr, wp_x, wp_y, start, route_len, abort,
    output carX, carY, nav_rWheel, nav_lWheel,
    input  tarX, tarY, rWheel, lWheel, wp_idx, wp_arrived, busy, done, dbg_state
  );
endinterface

// File: rtl/waypoint_sequencer.sv
// Route controller: steps through stored waypoints, settles on each, gates wheels.
// Optional WP_LOOP_EN: the route wraps to waypoint 0 forever instead of finishing.
module waypoint_sequencer #(
  parameter int NUM_WP        = 8,
  parameter int COORD_W       = 32,
  parameter int ARRIVE_TOL    = 50,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  waypoint_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_WP);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRIVE   = 3'd2,
    S_SETTLE  = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] tarx_q, tary_q;
  logic [1:0]         rwheel_q, rwheel_d, lwheel_q, lwheel_d;
  logic               arrived_q, arrived_d, busy_q, busy_d;
  logic               load_tar;

  logic [COORD_W-1:0] mem_x [NUM_WP];
  logic [COORD_W-1:0] mem_y [NUM_WP];

  logic [COORD_W-1:0] dx, dy;
  logic               in_tol;
  logic [AW:0]        len_clamped;
  logic               wr_en;

  // Distances are taken larger-minus-smaller so a car below the target never wraps.
  always_comb begin
    dx          = (bus.carX >= tarx_q) ? bus.carX - tarx_q : tarx_q - bus.carX;
    dy          = (bus.carY >= tary_q) ? bus.carY - tary_q : tary_q - bus.carY;
    in_tol      = (dx <= COORD_W'(ARRIVE_TOL)) && (dy <= COORD_W'(ARRIVE_TOL));
    len_clamped = (bus.route_len > (AW+1)'(NUM_WP)) ? (AW+1)'(NUM_WP) : bus.route_len;
    wr_en       = reset && bus.wp_we && !bus.abort &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[bus.wp_addr] <= bus.wp_x;
      mem_y[bus.wp_addr] <= bus.wp_y;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    load_tar = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          len_d   = len_clamped;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = (len_clamped == '0);
          state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load_tar = 1'b1;
        cnt_d    = '0;
        state_d  = S_DRIVE;
      end
      S_DRIVE: begin
        if (in_tol) begin
          cnt_d   = CW'(1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!in_tol) begin
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else if (cnt_q == CW'(SETTLE_CYCLES)) begin
          cnt_d   = '0;
          state_d = S_ADVANCE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ADVANCE: begin
        if ({1'b0, idx_q} == len_q - (AW+1)'(1)) begin
`ifdef WP_LOOP_EN
          idx_d   = '0;
          state_d = S_LOAD;
`else
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else, including a start or write in the same cycle.
    if (bus.abort) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
      load_tar = 1'b0;
    end

    // Registered outputs follow the next state so they line up with the state they describe.
    busy_d    = (state_d == S_LOAD) || (state_d == S_DRIVE) ||
                (state_d == S_SETTLE) || (state_d == S_ADVANCE);
    arrived_d = (state_d == S_ADVANCE);
    rwheel_d  = (state_d == S_DRIVE) ? bus.nav_rWheel : 2'b00;
    lwheel_d  = (state_d == S_DRIVE) ? bus.nav_lWheel : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      tarx_q    <= '0;
      tary_q    <= '0;
      rwheel_q  <= 2'b00;
      lwheel_q  <= 2'b00;
      arrived_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rwheel_q  <= rwheel_d;
      lwheel_q  <= lwheel_d;
      arrived_q <= arrived_d;
      busy_q    <= busy_d;
      if (load_tar) begin
        tarx_q <= mem_x[idx_q];
        tary_q <= mem_y[idx_q];
      end
    end
  end

  assign bus.tarX       = tarx_q;
  assign bus.tarY       = tary_q;
  assign bus.rWheel     = rwheel_q;
  assign bus.lWheel     = lwheel_q;
  assign bus.wp_idx     = idx_q;
  assign bus.wp_arrived = arrived_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_waypoint_sequencer.sv
// Bench for waypoint_sequencer: directed route scenarios plus a randomized run,
// all outputs compared every cycle against a route-level model.
module tb_waypoint_sequencer;
  localparam int NUM_WP = 8;
  localparam int COORD_W = 32;
  localparam int TOL = 50;
  localparam int SETTLE = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_TRACK = 2, P_ARRIVE = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  waypoint_sequencer_if #(.NUM_WP(NUM_WP), .COORD_W(COORD_W)) bus ();

  waypoint_sequencer #(
    .NUM_WP(NUM_WP), .COORD_W(COORD_W), .ARRIVE_TOL(TOL), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard counters
  int n_checks = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // route-level model: TRACK covers both driving and settling; streak counts
  // consecutive in-tolerance samples, wheels pass only while streak is zero.
  logic [31:0] m_mx [NUM_WP];
  logic [31:0] m_my [NUM_WP];
  int m_phase, m_len, m_idx, m_streak;
  logic [31:0] m_tarx, m_tary;
  logic [1:0] m_rw, m_lw;
  bit m_arr, m_busy, m_done;

  function automatic bit near(input logic [31:0] c, input logic [31:0] t);
    longint d;
    d = longint'({32'b0, c}) - longint'({32'b0, t});
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  always @(posedge clk) begin : model
    bit tol;
    tol = near(bus.carX, m_tarx) && near(bus.carY, m_tary);
    if (!reset) begin
      m_phase = P_IDLE; m_len = 0; m_idx = 0; m_streak = 0;
      m_tarx = 0; m_tary = 0; m_rw = 0; m_lw = 0;
      m_arr = 0; m_busy = 0; m_done = 0;
    end else begin
      if (bus.abort) begin
        m_phase = P_IDLE; m_idx = 0; m_streak = 0; m_done = 0;
      end else begin
        case (m_phase)
          P_IDLE, P_DONE: begin
            if (bus.wp_we) begin
              m_mx[bus.wp_addr] = bus.wp_x;
              m_my[bus.wp_addr] = bus.wp_y;
            end
            if (bus.start) begin
              m_len = (int'(bus.route_len) > NUM_WP) ? NUM_WP : int'(bus.route_len);
              m_idx = 0; m_streak = 0;
              m_done = (m_len == 0);
              m_phase = (m_len == 0) ? P_DONE : P_LOAD;
            end
          end
          P_LOAD: begin
            m_tarx = m_mx[m_idx]; m_tary = m_my[m_idx];
            m_streak = 0; m_phase = P_TRACK;
          end
          P_TRACK: begin
            if (!tol) m_streak = 0;
            else if (m_streak == SETTLE) begin m_streak = 0; m_phase = P_ARRIVE; end
            else m_streak++;
          end
          default: begin
            if (m_idx == m_len - 1) begin
`ifdef WP_LOOP_EN
              m_idx = 0; m_phase = P_LOAD;
`else
              m_done = 1; m_phase = P_DONE;
`endif
            end else begin
              m_idx++; m_phase = P_LOAD;
            end
          end
        endcase
      end
      m_busy = (m_phase == P_LOAD) || (m_phase == P_TRACK) || (m_phase == P_ARRIVE);
      m_arr  = (m_phase == P_ARRIVE);
      m_rw   = (m_phase == P_TRACK && m_streak == 0) ? bus.nav_rWheel : 2'b00;
      m_lw   = (m_phase == P_TRACK && m_streak == 0) ? bus.nav_lWheel : 2'b00;
    end
  end

  // every-cycle compare
  always @(negedge clk) begin
    if (check_en) begin
      check("tarX", bus.tarX, m_tarx);
      check("tarY", bus.tarY, m_tary);
      check("rWheel", bus.rWheel, m_rw);
      check("lWheel", bus.lWheel, m_lw);
      check("wp_idx", bus.wp_idx, m_idx);
      check("wp_arrived", bus.wp_arrived, m_arr);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_wp(input int a, input logic [31:0] x, input logic [31:0] y);
    bus.wp_we = 1'b1; bus.wp_addr = 3'(a); bus.wp_x = x; bus.wp_y = y;
    tick();
    bus.wp_we = 1'b0;
  endtask

  task automatic start_route(input int len);
    bus.start = 1'b1; bus.route_len = 4'(len);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic go_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic set_car(input logic [31:0] x, input logic [31:0] y);
    bus.carX = x; bus.carY = y;
  endtask

  task automatic wait_arrive(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.wp_arrived) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    bit arr_seen;
    bus.wp_we = 0; bus.wp_addr = 0; bus.wp_x = 0; bus.wp_y = 0;
    bus.start = 0; bus.route_len = 0; bus.abort = 0;
    bus.carX = 0; bus.carY = 0; bus.nav_rWheel = 2'b01; bus.nav_lWheel = 2'b10;

    // reset held for two clocks
    tick(); tick();
    check("rst_tarX", bus.tarX, 0);
    check("rst_tarY", bus.tarY, 0);
    check("rst_wheels", {bus.rWheel, bus.lWheel}, 0);
    check("rst_idx", bus.wp_idx, 0);
    check("rst_flags", {bus.wp_arrived, bus.busy, bus.done}, 0);
    check("rst_state", bus.dbg_state, 0);
    reset = 1'b1;
    check_en = 1'b1;

    for (int i = 2; i < NUM_WP; i++)
      write_wp(i, 32'($urandom_range(1000, 60000)), 32'($urandom_range(1000, 60000)));
    write_wp(0, 100, 100);
    write_wp(1, 500, 300);

    // two-waypoint route
    start_route(2);
    check("load_busy", bus.busy, 1);
    tick();
    check("tar0_x", bus.tarX, 100);
    check("tar0_y", bus.tarY, 100);
    check("drive_rw", bus.rWheel, 2'b01);
    check("drive_lw", bus.lWheel, 2'b10);
    set_car(120, 90);
    wait_arrive("arrive_wp0", 20);
    tick(); tick();
    check("tar1_x", bus.tarX, 500);
    check("tar1_y", bus.tarY, 300);
    check("idx1", bus.wp_idx, 1);

    // settle broken after three in-tolerance cycles
    set_car(520, 280);
    tick(); tick(); tick();
    check("settle_wheels", {bus.rWheel, bus.lWheel}, 0);
    set_car(200, 100);
    bus.nav_rWheel = 2'b11; bus.nav_lWheel = 2'b11;
    tick();
    check("rebreak_rw", bus.rWheel, 2'b11);
    check("rebreak_arr", bus.wp_arrived, 0);
    set_car(500, 300);
    wait_arrive("arrive_wp1", 20);
    tick();
`ifndef WP_LOOP_EN
    check("route_done", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("done_wheels", {bus.rWheel, bus.lWheel}, 0);
`endif

    // tolerance boundary: 51 out, 50 in, car below target
    go_idle();
    write_wp(0, 1000, 1000);
    set_car(1051, 1000);
    start_route(1);
    tick();
    check("tar_bound", bus.tarX, 1000);
    arr_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      arr_seen |= bus.wp_arrived;
    end
    check("dx51_no_arrive", arr_seen, 0);
    check("dx51_busy", bus.busy, 1);
    set_car(1050, 1000);
    wait_arrive("dx50_arrive", 20);
    go_idle();
    write_wp(0, 40, 40);
    set_car(0, 0);
    start_route(1);
    wait_arrive("nowrap_arrive", 20);

    // start while busy, then abort together with start and write
    go_idle();
    write_wp(0, 5000, 5000);
    set_car(5000, 5000);
    start_route(3);
    wait_arrive("abort_wp0", 20);
    tick(); tick();
    bus.start = 1'b1; bus.route_len = 4'd1;
    tick();
    bus.start = 1'b0;
    check("busy_start_idx", bus.wp_idx, 1);
    check("busy_start_busy", bus.busy, 1);
    bus.abort = 1'b1; bus.start = 1'b1; bus.route_len = 4'd2;
    bus.wp_we = 1'b1; bus.wp_addr = 3'd0; bus.wp_x = 7; bus.wp_y = 7;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.wp_we = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_wheels", {bus.rWheel, bus.lWheel}, 0);
    check("abort_idx", bus.wp_idx, 0);
    check("abort_done", bus.done, 0);
    check("abort_tar_hold", bus.tarX, 500);

    // empty route
    start_route(0);
    check("len0_busy", bus.busy, 0);
    tick();
    check("len0_done", bus.done, 1);
    check("len0_no_load", bus.busy, 0);

`ifdef WP_LOOP_EN
    go_idle();
    set_car(5000, 5000);
    start_route(2);
    wait_arrive("loop_wp0", 20);
    check("loop_idx0", bus.wp_idx, 0);
    set_car(500, 300);
    wait_arrive("loop_wp1", 20);
    check("loop_idx1", bus.wp_idx, 1);
    tick(); tick();
    check("loop_wrap_idx", bus.wp_idx, 0);
    check("loop_not_done", bus.done, 0);
`endif

    // randomized run
    go_idle();
    for (int c = 0; c < 3000; c++) begin
      bus.wp_we = 0; bus.start = 0; bus.abort = 0;
      if (m_phase == P_IDLE || m_phase == P_DONE) begin
        if ($urandom_range(0, 99) < 30) begin
          bus.wp_we = 1; bus.wp_addr = 3'($urandom_range(0, NUM_WP - 1));
          bus.wp_x = $urandom_range(1000, 60000); bus.wp_y = $urandom_range(1000, 60000);
        end
        if ($urandom_range(0, 99) < 25) begin
          bus.start = 1; bus.route_len = 4'($urandom_range(0, 15));
        end
      end else begin
        if ($urandom_range(0, 99) < 10) begin
          bus.wp_we = 1; bus.wp_addr = 3'($urandom_range(0, NUM_WP - 1));
          bus.wp_x = $urandom_range(0, 60000); bus.wp_y = $urandom_range(0, 60000);
        end
        if ($urandom_range(0, 99) < 5) begin
          bus.start = 1; bus.route_len = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 199) < 3) bus.abort = 1;
      end
      if ($urandom_range(0, 9) < 8) begin
        bus.carX = m_tarx + $urandom_range(0, 2 * TOL) - TOL;
        bus.carY = m_tary + $urandom_range(0, 2 * TOL) - TOL;
      end else begin
        bus.carX = m_tarx + TOL + 1 + $urandom_range(0, 300);
        bus.carY = m_tary - $urandom_range(0, 2 * TOL);
      end
      bus.nav_rWheel = 2'($urandom_range(0, 3));
      bus.nav_lWheel = 2'($urandom_range(0, 3));
      tick();
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
